ct_l2cache_dirty_array_ctrl: RTL and testbench

// - Parametrised L2 dirty/state array controller: owns a single-port SRAM of WAYS x BITS_PER_WAY bits per set.
// - Adds per-way masked writes, a valid/ready request port, and a hardware clear sweep, because the SRAM has no reset.
// - Sits between the L2 tag/dirty pipeline and the ct_spsram_NxM macro. The SRAM is external; this block drives its pins.

---
 rtl/ct_l2cache_dirty_array_ctrl_pkg.sv | 30 +++
 rtl/ct_l2cache_dirty_array_ctrl_init.sv | 70 +++++++
 rtl/ct_l2cache_dirty_array_ctrl.sv | 129 ++++++++++++
 tb/tb_ct_l2cache_dirty_array_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_l2cache_dirty_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_l2cache_dirty_array_ctrl_pkg
// Description : Shared definitions for the L2 dirty/state array controller:
//               FSM state encoding, data-width derivation helper and the
//               default set-index width for each supported L2 size.
// Revision    : 1.0 - initial release
// ============================================================================
package ct_l2cache_dirty_array_ctrl_pkg;

    // Set-index width per L2 size (64 B lines, 16 ways).
    localparam int unsigned c_L2C_IDX_W_256K      = 8;
    localparam int unsigned c_L2C_IDX_W_512K      = 9;
    localparam int unsigned c_L2C_IDX_W_1M        = 10;
    localparam int unsigned c_L2C_TAG_INDEX_WIDTH = c_L2C_IDX_W_512K;

    // INIT sweeps the array to zero; RUN serves requests.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dirty_state_e;

    // Total SRAM word width: one field of bits_per_way per way.
    function automatic int unsigned dirty_data_w(input int unsigned ways,
                                                 input int unsigned bits_per_way);
        return ways * bits_per_way;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ct_l2cache_dirty_array_ctrl_init.sv
`default_nettype none
// ============================================================================
// Module      : ct_l2cache_dirty_init_ctrl
// Description : Clear-sweep sequencer. Walks every set index once after reset
//               or after a clear request, then signals the array is usable.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_l2cache_dirty_init_ctrl
    import ct_l2cache_dirty_array_ctrl_pkg::*;
#(
    parameter int unsigned IDX_W = c_L2C_TAG_INDEX_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_req_i,
    output logic             sweep_o,
    output logic [IDX_W-1:0] sweep_idx_o,
    output logic             init_done_o
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = {IDX_W{1'b1}};

    dirty_state_e     state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    // State and sweep counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one index per cycle; a clear in RUN restarts the sweep,
    // a clear during INIT is ignored so the sweep always runs to completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_o     = 1'b0;
        init_done_o = 1'b0;
        case (state_q)
            ST_INIT: begin
                sweep_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                init_done_o = 1'b1;
                if (clr_req_i) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign sweep_idx_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ct_l2cache_dirty_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ct_l2cache_dirty_array_ctrl
// Description : L2 dirty/state array controller. Drives a single-port SRAM of
//               WAYS x BITS_PER_WAY bits per set: per-way masked writes,
//               valid/ready request port, hardware clear sweep.
//               Macro L2C_DIRTY_RD_FLOP_EN adds an output register stage on
//               the read path (latency 2 instead of 1, rd_data held).
// Revision    : 1.0 - initial release
// ============================================================================
module ct_l2cache_dirty_array_ctrl
    import ct_l2cache_dirty_array_ctrl_pkg::*;
#(
    parameter  int unsigned WAYS         = 16,
    parameter  int unsigned BITS_PER_WAY = 9,
    parameter  int unsigned IDX_W        = c_L2C_TAG_INDEX_WIDTH,
    localparam int unsigned DATA_W       = dirty_data_w(WAYS, BITS_PER_WAY)
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_wr,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic [WAYS-1:0]   req_way_mask,
    input  logic [DATA_W-1:0] req_din,
    input  logic              clr_req,
    output logic              init_done,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_cen,
    output logic              sram_gwen,
    output logic [IDX_W-1:0]  sram_idx,
    output logic [DATA_W-1:0] sram_din,
    output logic [DATA_W-1:0] sram_wen,
    input  logic [DATA_W-1:0] sram_dout
);

    logic              w_sweep;
    logic [IDX_W-1:0]  w_sweep_idx;
    logic              w_accept;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [DATA_W-1:0] w_wen_mask;
    logic              rd_vld_q, rd_vld_d;

    ct_l2cache_dirty_init_ctrl #(
        .IDX_W (IDX_W)
    ) u_init_ctrl (
        .clk_i       (forever_cpuclk),
        .rst_ni      (cpurst_b),
        .clr_req_i   (clr_req),
        .sweep_o     (w_sweep),
        .sweep_idx_o (w_sweep_idx),
        .init_done_o (init_done)
    );

    // The cycle carrying a clear is not a request slot.
    assign req_rdy  = init_done & ~clr_req;
    assign w_accept = req_vld & req_rdy;
    assign w_rd_acc = w_accept & ~req_wr;
    // An all-zero way mask is accepted but never touches the SRAM.
    assign w_wr_acc = w_accept & req_wr & (|req_way_mask);

    // Expand the per-way mask into the active-low bit write enable.
    for (genvar w = 0; w < WAYS; w++) begin : g_wen
        assign w_wen_mask[w*BITS_PER_WAY +: BITS_PER_WAY] = {BITS_PER_WAY{~req_way_mask[w]}};
    end

    // SRAM pin mux: the sweep owns the port, otherwise the accepted request;
    // held idle while reset is asserted so the macro sees no stray access.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_idx  = req_idx;
        sram_din  = '0;
        sram_wen  = '1;
        if (w_sweep && cpurst_b) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_idx  = w_sweep_idx;
            sram_wen  = '0;
        end else if (w_rd_acc) begin
            sram_cen  = 1'b0;
        end else if (w_wr_acc) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_din  = req_din;
            sram_wen  = w_wen_mask;
        end
    end

    assign rd_vld_d = w_rd_acc;

    // Track the read whose SRAM data appears on the next cycle.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
    end

`ifdef L2C_DIRTY_RD_FLOP_EN
    logic              rd_vld2_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    assign rd_data_d = rd_vld_q ? sram_dout : rd_data_q;

    // Output register stage: capture SRAM Q, hold it until the next read.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld2_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld2_q <= rd_vld_q;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_vld  = rd_vld2_q;
    assign rd_data = rd_data_q;
`else
    assign rd_vld  = rd_vld_q;
    assign rd_data = sram_dout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ct_l2cache_dirty_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_l2cache_dirty_array_ctrl
// Description : Self-checking bench for the L2 dirty array controller with a
//               behavioural SRAM, an array-level reference model and directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_l2cache_dirty_array_ctrl;

    localparam int WAYS  = 16;
    localparam int BPW   = 9;
    localparam int IDX_W = 4;
    localparam int DW    = WAYS * BPW;
    localparam int DEPTH = 1 << IDX_W;
`ifdef L2C_DIRTY_RD_FLOP_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_vld = 1'b0;
    logic             req_wr = 1'b0;
    logic             clr_req = 1'b0;
    logic [IDX_W-1:0] req_idx = '0;
    logic [WAYS-1:0]  req_way_mask = '0;
    logic [DW-1:0]    req_din = '0;
    logic             req_rdy, init_done, rd_vld;
    logic [DW-1:0]    rd_data;
    logic             sram_cen, sram_gwen;
    logic [IDX_W-1:0] sram_idx;
    logic [DW-1:0]    sram_din, sram_wen;
    logic [DW-1:0]    sram_dout;
    logic [DW-1:0]    sram_mem [DEPTH];

    int vectors = 0;
    int fails   = 0;

    ct_l2cache_dirty_array_ctrl #(
        .WAYS         (WAYS),
        .BITS_PER_WAY (BPW),
        .IDX_W        (IDX_W)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_idx        (req_idx),
        .req_way_mask   (req_way_mask),
        .req_din        (req_din),
        .clr_req        (clr_req),
        .init_done      (init_done),
        .rd_vld         (rd_vld),
        .rd_data        (rd_data),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_idx       (sram_idx),
        .sram_din       (sram_din),
        .sram_wen       (sram_wen),
        .sram_dout      (sram_dout)
    );

    initial forever #5 clk = ~clk;

    // Behavioural single-port SRAM, contents start unknown, Q holds between reads.
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = 'x;
        sram_dout = 'x;
    end
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_idx] = (sram_mem[sram_idx] & sram_wen) | (sram_din & ~sram_wen);
            else
                sram_dout <= sram_mem[sram_idx];
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: array contents, sweep progress and pending reads.
    // Evaluated at each falling edge with the inputs that the following
    // rising edge will act on.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_init = 1'b1;
    int            m_swept = 0;
    int            m_cyc = 0;
    int            due_q[$];
    logic [DW-1:0] dat_q[$];
    logic [DW-1:0] m_last = '0;
    int            low_cnt = 0;

    always @(negedge clk) begin
        logic [DW-1:0] bm;
        bit            exp_vld;
        if (!rst_n) begin
            chk("rst_rdy", DW'(req_rdy), DW'(0));
            chk("rst_init_done", DW'(init_done), DW'(0));
            chk("rst_rd_vld", DW'(rd_vld), DW'(0));
            chk("rst_cen", DW'(sram_cen), DW'(1));
            chk("rst_gwen", DW'(sram_gwen), DW'(1));
            chk("rst_wen", sram_wen, {DW{1'b1}});
`ifdef L2C_DIRTY_RD_FLOP_EN
            chk("rst_rd_data", rd_data, '0);
`endif
            m_init  = 1'b1;
            m_swept = 0;
            m_last  = '0;
            due_q.delete();
            dat_q.delete();
        end else begin
            if (!init_done) low_cnt++;
            exp_vld = (due_q.size() > 0) && (due_q[0] == m_cyc);
            chk("m_rd_vld", DW'(rd_vld), DW'(exp_vld));
            if (exp_vld) begin
                chk("m_rd_data", rd_data, dat_q[0]);
                m_last = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
`ifdef L2C_DIRTY_RD_FLOP_EN
            else chk("m_rd_hold", rd_data, m_last);
`endif
            if (m_init) begin
                chk("m_sw_done", DW'(init_done), DW'(0));
                chk("m_sw_rdy", DW'(req_rdy), DW'(0));
                chk("m_sw_cen", DW'(sram_cen), DW'(0));
                chk("m_sw_gwen", DW'(sram_gwen), DW'(0));
                chk("m_sw_idx", DW'(sram_idx), DW'(m_swept));
                chk("m_sw_wen", sram_wen, '0);
                chk("m_sw_din", sram_din, '0);
                m_mem[m_swept] = '0;
                m_swept++;
                if (m_swept == DEPTH) m_init = 1'b0;
            end else begin
                chk("m_done", DW'(init_done), DW'(1));
                chk("m_rdy", DW'(req_rdy), DW'(!clr_req));
                bm = '0;
                for (int w = 0; w < WAYS; w++)
                    if (req_way_mask[w]) bm[w*BPW +: BPW] = {BPW{1'b1}};
                if (req_vld && !clr_req && !req_wr) begin
                    chk("m_rd_cen", DW'(sram_cen), DW'(0));
                    chk("m_rd_gwen", DW'(sram_gwen), DW'(1));
                    chk("m_rd_idx", DW'(sram_idx), DW'(req_idx));
                    due_q.push_back(m_cyc + LAT);
                    dat_q.push_back(m_mem[req_idx]);
                end else if (req_vld && !clr_req && req_wr && req_way_mask != '0) begin
                    chk("m_wr_cen", DW'(sram_cen), DW'(0));
                    chk("m_wr_gwen", DW'(sram_gwen), DW'(0));
                    chk("m_wr_idx", DW'(sram_idx), DW'(req_idx));
                    chk("m_wr_din", sram_din, req_din);
                    chk("m_wr_wen", sram_wen, ~bm);
                    m_mem[req_idx] = (m_mem[req_idx] & ~bm) | (req_din & bm);
                end else begin
                    chk("m_idle_cen", DW'(sram_cen), DW'(1));
                end
                if (clr_req) begin
                    m_init  = 1'b1;
                    m_swept = 0;
                end
            end
        end
        m_cyc++;
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // ------------------------------------------------------------------
    task automatic issue(input logic wr, input logic [IDX_W-1:0] idx,
                         input logic [WAYS-1:0] m, input logic [DW-1:0] d);
        req_vld = 1'b1; req_wr = wr; req_idx = idx; req_way_mask = m; req_din = d;
        @(posedge clk); #1;
        req_vld = 1'b0; req_wr = 1'b0; req_way_mask = '0; req_din = '0;
    endtask

    task automatic do_read(input logic [IDX_W-1:0] idx, output logic [DW-1:0] d, output int lat);
        issue(1'b0, idx, '0, '0);
        lat = 1;
        d   = 'x;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rd_vld) begin
                d = rd_data;
                break;
            end
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (init_done) break;
            n++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] got;
        logic [DW-1:0] ones;
        logic [DW-1:0] top_way;
        bit            got_vld;
        int            lat, n;

        ones    = {DW{1'b1}};
        top_way = {9'h1FF, {(DW-BPW){1'b0}}};

        // Reset, then the power-on sweep.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lit_rst_cen", DW'(sram_cen), DW'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init(n);
        chk("lit_sweep_len", DW'(n), DW'(16));

        // Every entry reads back zero after the sweep.
        for (int i = 0; i < DEPTH; i++) begin
            do_read(IDX_W'(i), d, lat);
            chk("lit_clear_rd", d, '0);
        end
        chk("lit_rd_lat", DW'(lat), DW'(LAT));

        // Way 0 write, then readback.
        issue(1'b1, 4'd3, 16'h0001, ones);
        do_read(4'd3, d, lat);
        chk("lit_way0", d, 144'h1FF);

        // Way 15 write, read on the very next cycle.
        issue(1'b1, 4'd5, 16'h8000, ones);
        do_read(4'd5, d, lat);
        chk("lit_way15", d, top_way);
        chk("lit_way15_lat", DW'(lat), DW'(LAT));

        // All-zero mask: accepted but no SRAM access, entry unchanged.
        req_vld = 1'b1; req_wr = 1'b1; req_idx = 4'd3; req_way_mask = '0; req_din = '0;
        @(negedge clk);
        chk("lit_m0_rdy", DW'(req_rdy), DW'(1));
        chk("lit_m0_cen", DW'(sram_cen), DW'(1));
        @(posedge clk); #1;
        req_vld = 1'b0; req_wr = 1'b0;
        do_read(4'd3, d, lat);
        chk("lit_m0_keep", d, 144'h1FF);

        // Read in flight across a clear.
        issue(1'b0, 4'd3, '0, '0);
        clr_req = 1'b1;
        got_vld = 1'b0;
        got     = '0;
        @(negedge clk);
        chk("lit_clr_done_hi", DW'(init_done), DW'(1));
        if (rd_vld) begin got = rd_data; got_vld = 1'b1; end
        @(posedge clk); #1;
        clr_req = 1'b0;
        @(negedge clk);
        chk("lit_clr_done_lo", DW'(init_done), DW'(0));
        if (!got_vld && rd_vld) begin got = rd_data; got_vld = 1'b1; end
        chk("lit_clr_rd", got, 144'h1FF);
        @(posedge clk); #1;
        wait_init(n);
        chk("lit_clr_len", DW'(n + 1), DW'(16));
        do_read(4'd3, d, lat);
        chk("lit_clr_rd0", d, '0);

        // Reset asserted at sweep index 7, sweep restarts from 0.
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        got_vld = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!sram_cen && sram_idx == 4'd7) begin got_vld = 1'b1; break; end
        end
        chk("lit_hit_idx7", DW'(got_vld), DW'(1));
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("lit_mid_cen", DW'(sram_cen), DW'(1));
        chk("lit_mid_done", DW'(init_done), DW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init(n);
        chk("lit_mid_len", DW'(n), DW'(16));
        do_read(4'd5, d, lat);
        chk("lit_mid_rd0", d, '0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
